// File: rtl/tinyqv_mem_pkg.sv
// Shared encodings, FSM state type and load-alignment helper for the data responder.
package tinyqv_mem_pkg;

  // Access size encodings carried in mem_op[1:0].
  localparam logic [1:0] MEM_OP_BYTE = 2'b00;
  localparam logic [1:0] MEM_OP_HALF = 2'b01;
  localparam logic [1:0] MEM_OP_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Shift the addressed byte/half down to bit 0 and clear everything above it.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = '0;
    res = word;
    case (size)
      MEM_OP_BYTE: begin
        sh  = word >> {off, 3'b000};
        res = {24'h0, sh[7:0]};
      end
      MEM_OP_HALF: begin
        sh  = word >> {off[1], 4'b0000};
        res = {16'h0, sh[15:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tinyqv_mem_array.sv
// Flop-based word array: byte-enable synchronous write, asynchronous read. Contents not reset.
module tinyqv_mem_array #(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned WORD_BITS = 4
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [WORD_BITS-1:0] i_waddr,
  input  logic [3:0]           i_be,
  input  logic [31:0]          i_wdata,
  input  logic [WORD_BITS-1:0] i_raddr,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [NUM_WORDS];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tinyqv_data_responder.sv
// Responder for the core's nibble-serial load/store port, backed by a small flop array.
// Stores commit on address_ready; loads answer one aligned 8-nibble window later.
module tinyqv_data_responder
  import tinyqv_mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS    = 16,
  parameter int unsigned WORD_BITS    = 4,
  parameter int unsigned WAIT_WINDOWS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  counter,
  input  logic [27:0] addr_in,
  input  logic        address_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [3:0]  data_from_core,
  output logic [3:0]  data_to_core,
  output logic        load_data_ready
);

  localparam int unsigned WcntW = (WAIT_WINDOWS > 1) ? $clog2(WAIT_WINDOWS) : 1;

  logic [27:0]          r_store_sh;
  logic [31:0]          w_store_word;
  logic                 w_mapped;
  logic                 w_store_fire;
  logic                 w_load_fire;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;

  state_e               r_state;
  state_e               w_state_next;
  logic [WcntW-1:0]     r_wcnt;
  logic [WcntW-1:0]     w_wcnt_next;

  logic [WORD_BITS-1:0] r_ld_idx;
  logic [1:0]           r_ld_off;
  logic [1:0]           r_ld_size;
  logic                 r_ld_mapped;
  logic [31:0]          w_rdata;
  logic [31:0]          w_aligned;

  logic [31:0]          r_oshreg;
  logic [31:0]          w_oshreg_next;
  logic                 r_ldr;
  logic                 w_ldr_next;
  logic [3:0]           r_dout;
  logic [3:0]           w_dout_next;

  // Signedness bit is handled by the core; nothing to do with it here.
  logic                 w_unused_sign;
  assign w_unused_sign = mem_op[2];

  assign w_store_word = {data_from_core, r_store_sh};
  assign w_mapped     = (addr_in[27:WORD_BITS+2] == '0);
  // address_ready outside IDLE is a protocol violation and is dropped entirely.
  assign w_store_fire = address_ready && is_store && (r_state == StIdle) && w_mapped;
  assign w_load_fire  = address_ready && is_load && !is_store && (r_state == StIdle);

  // Store nibbles arrive LSB first, so shift new nibbles in at the top.
  always_ff @(posedge clk) begin
    r_store_sh <= {data_from_core, r_store_sh[27:4]};
  end

  // Replicate store data across lanes and pick the byte enables.
  always_comb begin
    w_wdata = w_store_word;
    w_be    = 4'b1111;
    case (mem_op[1:0])
      MEM_OP_BYTE: begin
        w_wdata = {4{w_store_word[7:0]}};
        w_be    = 4'b0001 << addr_in[1:0];
      end
      MEM_OP_HALF: begin
        w_wdata = {2{w_store_word[15:0]}};
        w_be    = addr_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = w_store_word;
        w_be    = 4'b1111;
      end
    endcase
  end

  tinyqv_mem_array #(
    .NUM_WORDS(NUM_WORDS),
    .WORD_BITS(WORD_BITS)
  ) u_array (
    .clk    (clk),
    .i_we   (w_store_fire),
    .i_waddr(addr_in[WORD_BITS+1:2]),
    .i_be   (w_be),
    .i_wdata(w_wdata),
    .i_raddr(r_ld_idx),
    .o_rdata(w_rdata)
  );

  // Unmapped loads still get a response window, just with zero data.
  assign w_aligned = r_ld_mapped ? align_load(w_rdata, r_ld_size, r_ld_off) : 32'h0;

  // Capture the load request so the read happens late, after any earlier store.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_ld_idx    <= addr_in[WORD_BITS+1:2];
      r_ld_off    <= addr_in[1:0];
      r_ld_size   <= mem_op[1:0];
      r_ld_mapped <= w_mapped;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // FSM next-state: transitions only ever happen on counter==7.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (w_load_fire) w_state_next = StWait;
      StWait: if ((counter == 3'd7) && (r_wcnt == '0)) w_state_next = StResp;
      StResp: if (counter == 3'd7) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: wait count, response shift register and next output nibble.
  always_comb begin
    w_wcnt_next   = r_wcnt;
    w_oshreg_next = r_oshreg;
    w_ldr_next    = 1'b0;
    w_dout_next   = 4'h0;
    case (r_state)
      StIdle: begin
        if (w_load_fire) w_wcnt_next = WcntW'(WAIT_WINDOWS - 1);
      end
      StWait: begin
        if (counter == 3'd7) begin
          if (r_wcnt == '0) begin
            w_ldr_next    = 1'b1;
            w_dout_next   = w_aligned[3:0];
            w_oshreg_next = w_aligned >> 4;
          end else begin
            w_wcnt_next = r_wcnt - WcntW'(1);
          end
        end
      end
      StResp: begin
        // Last nibble goes out on counter==7; drop ready for the following clock.
        if (counter != 3'd7) begin
          w_ldr_next    = 1'b1;
          w_dout_next   = r_oshreg[3:0];
          w_oshreg_next = r_oshreg >> 4;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt   <= '0;
      r_oshreg <= '0;
      r_ldr    <= 1'b0;
      r_dout   <= 4'h0;
    end else begin
      r_wcnt   <= w_wcnt_next;
      r_oshreg <= w_oshreg_next;
      r_ldr    <= w_ldr_next;
      r_dout   <= w_dout_next;
    end
  end

  assign load_data_ready = r_ldr;
  assign data_to_core    = r_dout;

endmodule

// File: tb/tb_tinyqv_data_responder.sv
// Directed bench for tinyqv_data_responder: one default instance plus a WAIT_WINDOWS=3 instance.
module tb_tinyqv_data_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  counter;
  logic [27:0] addr_in;
  logic        address_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  mem_op;
  logic [3:0]  data_from_core;
  logic [3:0]  dout0, dout3;
  logic        ldr0, ldr3;

  int          n_checks;
  int          n_fail;
  int          zero_viol;
  logic        chk_idle;

  logic [7:0]  cap_rdy0, cap_rdy3;
  logic [31:0] cap_dat0, cap_dat3;

  localparam logic [2:0] OpB = 3'b000;
  localparam logic [2:0] OpH = 3'b001;
  localparam logic [2:0] OpW = 3'b010;

  tinyqv_data_responder #(
    .NUM_WORDS(16), .WORD_BITS(4), .WAIT_WINDOWS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .counter(counter), .addr_in(addr_in),
    .address_ready(address_ready), .is_load(is_load), .is_store(is_store),
    .mem_op(mem_op), .data_from_core(data_from_core),
    .data_to_core(dout0), .load_data_ready(ldr0)
  );

  tinyqv_data_responder #(
    .NUM_WORDS(16), .WORD_BITS(4), .WAIT_WINDOWS(3)
  ) dut3 (
    .clk(clk), .rst(rst), .counter(counter), .addr_in(addr_in),
    .address_ready(address_ready), .is_load(is_load), .is_store(is_store),
    .mem_op(mem_op), .data_from_core(data_from_core),
    .data_to_core(dout3), .load_data_ready(ldr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One core cycle (counter 0..7); outputs sampled mid-period into cap_*.
  task automatic run_cycle(input logic ar, input logic ld, input logic st, input logic [2:0] op,
                           input logic [27:0] addr, input logic [31:0] sd, input int rst_at);
    cap_rdy0 = '0; cap_dat0 = '0; cap_rdy3 = '0; cap_dat3 = '0;
    for (int k = 0; k < 8; k++) begin
      counter        = 3'(k);
      data_from_core = sd[4*k +: 4];
      address_ready  = ar && (k == 7);
      is_load        = ld;
      is_store       = st;
      mem_op         = op;
      addr_in        = addr;
      if (rst_at >= 0) rst = (k == rst_at);
      if (ldr0 === 1'b1) begin
        cap_rdy0[k] = 1'b1;
        cap_dat0[4*k +: 4] = dout0;
      end else if (chk_idle && (dout0 !== 4'h0)) begin
        zero_viol++;
      end
      if (ldr3 === 1'b1) begin
        cap_rdy3[k] = 1'b1;
        cap_dat3[4*k +: 4] = dout3;
      end else if (chk_idle && (dout3 !== 4'h0)) begin
        zero_viol++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, 1'b0, OpW, 28'h0, 32'h0, -1);
  endtask

  task automatic do_store(input logic [27:0] addr, input logic [2:0] op, input logic [31:0] d);
    run_cycle(1'b1, 1'b0, 1'b1, op, addr, d, -1);
  endtask

  task automatic do_load(input string tag, input logic [27:0] addr, input logic [2:0] op,
                         input logic [31:0] exp);
    run_cycle(1'b1, 1'b1, 1'b0, op, addr, 32'h0, -1);
    idle_cycle();
    check({tag, "_early"}, {24'h0, cap_rdy0}, 32'h0);
    idle_cycle();
    check({tag, "_rdy"}, {24'h0, cap_rdy0}, 32'h0000_00FF);
    check({tag, "_dat"}, cap_dat0, exp);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; zero_viol = 0; chk_idle = 1'b0;
    rst = 1'b1; counter = 3'd0; addr_in = '0; address_ready = 1'b0;
    is_load = 1'b0; is_store = 1'b0; mem_op = OpW; data_from_core = 4'h0;

    idle_cycle();
    rst = 1'b0;
    chk_idle = 1'b1;
    check("rst_ldr0", {31'h0, ldr0}, 32'h0);
    check("rst_dout0", {28'h0, dout0}, 32'h0);
    idle_cycle();
    check("rst_idle_rdy", {16'h0, cap_rdy3, cap_rdy0}, 32'h0);

    // Word store then word load; both latencies observed side by side.
    do_store(28'h08, OpW, 32'hDEAD_BEEF);
    run_cycle(1'b1, 1'b1, 1'b0, OpW, 28'h08, 32'h0, -1);
    check("lat_c0", {16'h0, cap_rdy3, cap_rdy0}, 32'h0);
    idle_cycle();
    check("lat_c1", {16'h0, cap_rdy3, cap_rdy0}, 32'h0);
    idle_cycle();
    check("lat_c2_rdy", {16'h0, cap_rdy3, cap_rdy0}, 32'h0000_00FF);
    check("lat_c2_dat", cap_dat0, 32'hDEAD_BEEF);
    idle_cycle();
    check("lat_c3", {16'h0, cap_rdy3, cap_rdy0}, 32'h0);
    idle_cycle();
    check("ww3_c4_rdy", {16'h0, cap_rdy3, cap_rdy0}, 32'h0000_FF00);
    check("ww3_c4_dat", cap_dat3, 32'hDEAD_BEEF);
    idle_cycle();
    check("ww3_c5", {16'h0, cap_rdy3, cap_rdy0}, 32'h0);

    // Byte store into an existing word, then aligned sub-word loads.
    do_store(28'h0C, OpW, 32'h1122_3344);
    do_store(28'h0D, OpB, 32'h0000_005A);
    do_load("ld_w0c", 28'h0C, OpW, 32'h1122_5A44);
    do_load("ld_h0e", 28'h0E, OpH, 32'h0000_1122);
    do_load("ld_b0f", 28'h0F, OpB, 32'h0000_0011);

    // Half store with addr[0] set lands in the upper half.
    do_store(28'h0B, OpH, 32'h0000_CAFE);
    do_load("ld_w08", 28'h08, OpW, 32'hCAFE_BEEF);
    do_load("ld_h08", 28'h08, OpH, 32'h0000_BEEF);
    do_load("ld_b09", 28'h09, OpB, 32'h0000_00BE);

    // Word store ignores addr[1:0].
    do_store(28'h13, OpW, 32'h0123_4567);
    do_load("ld_w10", 28'h10, OpW, 32'h0123_4567);

    // Unmapped store dropped; unmapped load answers zero.
    do_store(28'h00, OpW, 32'hA5A5_A5A5);
    do_store(28'h0100_0040, OpW, 32'hFFFF_FFFF);
    do_load("ld_unmap", 28'h0100_0040, OpW, 32'h0);
    do_load("ld_w00", 28'h00, OpW, 32'hA5A5_A5A5);
    do_load("ld_w08b", 28'h08, OpW, 32'hCAFE_BEEF);

    // Load and store together: store only, no response.
    run_cycle(1'b1, 1'b1, 1'b1, OpW, 28'h14, 32'h7777_7777, -1);
    idle_cycle();
    check("ldst_c1", {24'h0, cap_rdy0}, 32'h0);
    idle_cycle();
    check("ldst_c2", {24'h0, cap_rdy0}, 32'h0);
    do_load("ld_w14", 28'h14, OpW, 32'h7777_7777);

    // Store presented while waiting is ignored; pending load unaffected.
    run_cycle(1'b1, 1'b1, 1'b0, OpW, 28'h0C, 32'h0, -1);
    run_cycle(1'b1, 1'b0, 1'b1, OpW, 28'h0C, 32'h0, -1);
    idle_cycle();
    check("ign_rdy", {24'h0, cap_rdy0}, 32'h0000_00FF);
    check("ign_dat", cap_dat0, 32'h1122_5A44);
    do_load("ld_w0c_after", 28'h0C, OpW, 32'h1122_5A44);

    // Reset pulse while waiting discards the load.
    run_cycle(1'b1, 1'b1, 1'b0, OpW, 28'h08, 32'h0, -1);
    run_cycle(1'b0, 1'b0, 1'b0, OpW, 28'h0, 32'h0, 3);
    idle_cycle();
    check("rstw_c2", {16'h0, cap_rdy3, cap_rdy0}, 32'h0);
    idle_cycle();
    check("rstw_c3", {24'h0, cap_rdy0}, 32'h0);
    do_load("ld_after_rst", 28'h08, OpW, 32'hCAFE_BEEF);

    check("idle_zero", zero_viol, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
